ysyx_23060025_ex_muldiv: RTL

Parametrised multi-cycle RV32M multiply/divide unit for the execute stage. Covers all eight M-extension operations. The EX stage launches an operation through a valid/ready handshake and holds its ready-go low until the result handshake completes. This generalises the single-cycle ALU path to variable-latency, back-pressurable execution with flush support.

---
 rtl/ysyx_23060025_ex_muldiv_pkg.sv | 40 ++++
 rtl/ysyx_23060025_ex_muldiv_mul_array.sv | 23 ++
 rtl/ysyx_23060025_ex_muldiv.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060025_ex_muldiv_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_23060025_ex_muldiv_pkg
//   Shared definitions for the RV32M multiply/divide unit.
//   - MD_OP_* : 3-bit operation encodings. They follow the RV32M funct3 field,
//     so the decode stage can forward funct3 unchanged.
//   - Helper functions that classify an operation: signedness of each operand,
//     divide-vs-multiply, and remainder-vs-quotient.
//   Optional feature macro used by the unit: YSYX_23060025_FAST_MUL_EN.
// ----------------------------------------------------------------------------
package ysyx_23060025_ex_muldiv_pkg;

    localparam logic [2:0] MD_OP_MUL    = 3'b000;
    localparam logic [2:0] MD_OP_MULH   = 3'b001;
    localparam logic [2:0] MD_OP_MULHSU = 3'b010;
    localparam logic [2:0] MD_OP_MULHU  = 3'b011;
    localparam logic [2:0] MD_OP_DIV    = 3'b100;
    localparam logic [2:0] MD_OP_DIVU   = 3'b101;
    localparam logic [2:0] MD_OP_REM    = 3'b110;
    localparam logic [2:0] MD_OP_REMU   = 3'b111;

    // rs1 is interpreted as signed for MULH, MULHSU, DIV and REM.
    function automatic logic md_src1_signed(input logic [2:0] op);
        return (op == MD_OP_MULH) || (op == MD_OP_MULHSU) ||
               (op == MD_OP_DIV)  || (op == MD_OP_REM);
    endfunction

    // rs2 is interpreted as signed for MULH, DIV and REM (not MULHSU).
    function automatic logic md_src2_signed(input logic [2:0] op);
        return (op == MD_OP_MULH) || (op == MD_OP_DIV) || (op == MD_OP_REM);
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic md_is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/ysyx_23060025_ex_muldiv_mul_array.sv
// ----------------------------------------------------------------------------
// ysyx_23060025_mul_array
//   Combinational unsigned W x W -> 2W multiplier used by the single-cycle
//   multiply path. The module only exists when YSYX_23060025_FAST_MUL_EN is
//   defined; otherwise no multiplier array is present in the design.
//   Ports:
//     a_i  in  W    unsigned multiplicand magnitude
//     b_i  in  W    unsigned multiplier magnitude
//     p_o  out 2W   full unsigned product
// ----------------------------------------------------------------------------
`ifdef YSYX_23060025_FAST_MUL_EN
module ysyx_23060025_mul_array #(
    parameter int W = 32
) (
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic [2*W-1:0] p_o
);

    assign p_o = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};

endmodule
`endif

// File: rtl/ysyx_23060025_ex_muldiv.sv
// ----------------------------------------------------------------------------
// ysyx_23060025_ex_muldiv
//   Multi-cycle RV32M multiply/divide unit for the execute stage. Handles all
//   eight M-extension operations with a shift-add multiplier and a restoring
//   divider sharing one 2*DATA_LEN working register.
//
//   Handshake: a transfer happens on a rising clock edge where valid and ready
//   are both high. in_ready_o is high only in IDLE; out_valid_o is high only in
//   DONE and the result is held stable until out_ready_i is seen.
//
//   Ports:
//     clock        in   sole clock, posedge
//     reset        in   asynchronous, active-high
//     in_valid_i   in   operation request valid
//     in_ready_o   out  unit can accept (IDLE)
//     op_i         in   MD_OP_* encoding
//     src1_i       in   rs1 (multiplicand / dividend)
//     src2_i       in   rs2 (multiplier / divisor)
//     flush_i      in   abort current operation, wins over accept
//     out_valid_o  out  result valid (registered)
//     out_ready_i  in   consumer accepts result
//     result_o     out  result (registered)
//     busy_o       out  state != IDLE
//
//   Macro: YSYX_23060025_FAST_MUL_EN selects a single-cycle combinational
//   multiplier for MUL/MULH/MULHSU/MULHU; divide stays iterative.
// ----------------------------------------------------------------------------
module ysyx_23060025_ex_muldiv
    import ysyx_23060025_ex_muldiv_pkg::*;
#(
    parameter int DATA_LEN = 32,
    parameter int CNT_W    = $clog2(DATA_LEN) + 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [2:0]          op_i,
    input  logic [DATA_LEN-1:0] src1_i,
    input  logic [DATA_LEN-1:0] src2_i,
    input  logic                flush_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [DATA_LEN-1:0] result_o,
    output logic                busy_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]    LAST_STEP = CNT_W'(DATA_LEN);
    localparam logic [DATA_LEN-1:0] MOST_NEG  = {1'b1, {(DATA_LEN-1){1'b0}}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]            state_q,  state_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic [2:0]            op_q,     op_d;
    logic                  sign1_q,  sign1_d;
    logic                  sign2_q,  sign2_d;
    // opa: multiplicand (mul) or divisor (div); opb: seed for the low half
    logic [DATA_LEN-1:0]   opa_q,    opa_d;
    logic [DATA_LEN-1:0]   opb_q,    opb_d;
    logic [2*DATA_LEN-1:0] prod_q,   prod_d;
    logic [DATA_LEN-1:0]   result_q, result_d;

    // ------------------------------------------------------------------
    // Accept-side decode
    // ------------------------------------------------------------------
    logic                src1_neg, src2_neg;
    logic [DATA_LEN-1:0] src1_mag, src2_mag;
    logic                in_is_div, in_is_rem;
    logic                div_zero, div_ovf;
    logic [DATA_LEN-1:0] special_res;

    assign src1_neg  = md_src1_signed(op_i) & src1_i[DATA_LEN-1];
    assign src2_neg  = md_src2_signed(op_i) & src2_i[DATA_LEN-1];
    // The most-negative value maps to itself, which is the correct unsigned
    // magnitude 2^(DATA_LEN-1).
    assign src1_mag  = src1_neg ? -src1_i : src1_i;
    assign src2_mag  = src2_neg ? -src2_i : src2_i;
    assign in_is_div = md_is_div(op_i);
    assign in_is_rem = md_is_rem(op_i);

    assign div_zero  = (src2_i == '0);
    assign div_ovf   = ((op_i == MD_OP_DIV) || (op_i == MD_OP_REM)) &&
                       (src1_i == MOST_NEG) && (src2_i == '1);

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = in_is_rem ? src1_i : '1;
        end else begin
            special_res = in_is_rem ? '0 : src1_i;
        end
    end

`ifdef YSYX_23060025_FAST_MUL_EN
    logic [2*DATA_LEN-1:0] fast_prod;
    logic [2*DATA_LEN-1:0] fast_full;
    logic [DATA_LEN-1:0]   fast_res;

    ysyx_23060025_mul_array #(
        .W (DATA_LEN)
    ) u_mul_array (
        .a_i (src1_mag),
        .b_i (src2_mag),
        .p_o (fast_prod)
    );

    assign fast_full = (src1_neg ^ src2_neg) ? -fast_prod : fast_prod;
    assign fast_res  = (op_i == MD_OP_MUL) ? fast_full[DATA_LEN-1:0]
                                           : fast_full[2*DATA_LEN-1:DATA_LEN];
`endif

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    // Multiply: low half holds the remaining multiplier bits, high half the
    // partial sum; add the multiplicand on a set LSB, then shift right with
    // the carry coming in at the top.
    logic [DATA_LEN-1:0]   mul_addend;
    logic [DATA_LEN:0]     mul_sum;
    logic [2*DATA_LEN-1:0] mul_next;

    assign mul_addend = prod_q[0] ? opa_q : {DATA_LEN{1'b0}};
    assign mul_sum    = {1'b0, prod_q[2*DATA_LEN-1:DATA_LEN]} + {1'b0, mul_addend};
    assign mul_next   = {mul_sum, prod_q[DATA_LEN-1:1]};

    // Divide: high half is the partial remainder, low half shifts the
    // dividend out and the quotient bits in.
    logic [DATA_LEN:0]     rem_shift;
    logic [DATA_LEN-1:0]   rem_sub;
    logic                  div_ge;
    logic [2*DATA_LEN-1:0] div_next;

    assign rem_shift = prod_q[2*DATA_LEN-1:DATA_LEN-1];
    assign div_ge    = (rem_shift >= {1'b0, opa_q});
    assign rem_sub   = rem_shift[DATA_LEN-1:0] - opa_q;
    assign div_next  = {(div_ge ? rem_sub : rem_shift[DATA_LEN-1:0]),
                        prod_q[DATA_LEN-2:0], div_ge};

    // ------------------------------------------------------------------
    // Sign fix-up and half selection
    // ------------------------------------------------------------------
    logic [2*DATA_LEN-1:0] mul_full;
    logic [DATA_LEN-1:0]   quo_fix, rem_fix, fix_res;

    assign mul_full = (sign1_q ^ sign2_q) ? -prod_q : prod_q;
    assign quo_fix  = (sign1_q ^ sign2_q) ? -prod_q[DATA_LEN-1:0]
                                          : prod_q[DATA_LEN-1:0];
    assign rem_fix  = sign1_q ? -prod_q[2*DATA_LEN-1:DATA_LEN]
                              : prod_q[2*DATA_LEN-1:DATA_LEN];

    always_comb begin
        fix_res = '0;
        if (md_is_div(op_q)) begin
            fix_res = md_is_rem(op_q) ? rem_fix : quo_fix;
        end else if (op_q == MD_OP_MUL) begin
            fix_res = mul_full[DATA_LEN-1:0];
        end else begin
            fix_res = mul_full[2*DATA_LEN-1:DATA_LEN];
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign1_d  = sign1_q;
        sign2_d  = sign2_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        prod_d   = prod_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid_i && !flush_i) begin
                    op_d    = op_i;
                    sign1_d = src1_neg;
                    sign2_d = src2_neg;
                    opa_d   = in_is_div ? src2_mag : src1_mag;
                    opb_d   = in_is_div ? src1_mag : src2_mag;
                    cnt_d   = '0;
                    if (in_is_div && (div_zero || div_ovf)) begin
                        result_d = special_res;
                        state_d  = S_DONE;
`ifdef YSYX_23060025_FAST_MUL_EN
                    end else if (!in_is_div) begin
                        result_d = fast_res;
                        state_d  = S_DONE;
`endif
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + CNT_ONE;
                // The first CALC cycle seeds the working register; the
                // following DATA_LEN cycles each perform one step.
                if (cnt_q == '0) begin
                    prod_d = {{DATA_LEN{1'b0}}, opb_q};
                end else begin
                    prod_d = md_is_div(op_q) ? div_next : mul_next;
                end
                if (cnt_q == LAST_STEP) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = fix_res;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush drops the operation wherever it is; the held result is kept
        // untouched so a flushed FIX cycle cannot alter result_o.
        if (flush_i) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= MD_OP_MUL;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            prod_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign1_q  <= sign1_d;
            sign2_q  <= sign2_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            prod_q   <= prod_d;
            result_q <= result_d;
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign busy_o      = (state_q != S_IDLE);
    assign result_o    = result_q;

endmodule
